// File: rtl/cricket_pkg.sv
// Shared definitions for the cricket innings sequencer: match phases,
// the wicket outcome code, default match limits and the run adder.
package cricket_pkg;

   // Match phase: first innings, break between innings, chase, result.
   typedef enum logic [1:0] {
      ST_INN1  = 2'd0,
      ST_BREAK = 2'd1,
      ST_INN2  = 2'd2,
      ST_DONE  = 2'd3
   } innings_state_e;

   // Outcome code that means "batter out" instead of a run count.
   localparam logic [2:0] OUTCOME_WICKET = 3'd7;

   // Default match limits.
   localparam int DEF_MAX_OVERS      = 2;
   localparam int DEF_BALLS_PER_OVER = 6;
   localparam int DEF_MAX_WICKETS    = 10;

   // Add a ball's runs to the score, pinning the score at 255 rather than wrapping.
   function automatic logic [7:0] sat_add_runs(input logic [7:0] runs_in,
                                                input logic [2:0] add_in);
      logic [8:0] sum_v;
      sum_v = {1'b0, runs_in} + {6'd0, add_in};
      if (sum_v[8]) begin
         return 8'hFF;
      end else begin
         return sum_v[7:0];
      end
   endfunction

endpackage

// File: rtl/ball_counter.sv
// Counts legal deliveries within the over and completed overs. Flags, one
// cycle ahead of the registers, the ball that completes the last allowed over.
module ball_counter
   import cricket_pkg::*;
#(
   parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
   parameter int MAX_OVERS      = DEF_MAX_OVERS
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic       advance,
   input  logic       clear,
   output logic [2:0] balls,
   output logic [3:0] overs,
   output logic       over_limit
);

   localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);
   localparam logic [3:0] LAST_OVER = 4'(MAX_OVERS - 1);

   logic [2:0] balls_r;
   logic [3:0] overs_r;
   logic       wrap_s;

   // Decide whether the ball being counted closes the over, and whether it closes the final over.
   always_comb begin
      wrap_s     = 1'b0;
      over_limit = 1'b0;
      if (advance && (balls_r == LAST_BALL)) begin
         wrap_s = 1'b1;
         if (overs_r == LAST_OVER) begin
            over_limit = 1'b1;
         end else begin
            over_limit = 1'b0;
         end
      end else begin
         wrap_s     = 1'b0;
         over_limit = 1'b0;
      end
   end

   // Ball and over registers; clear starts a fresh innings.
   always_ff @(posedge clk_fpga or negedge reset) begin
      if (!reset) begin
         balls_r <= 3'd0;
         overs_r <= 4'd0;
      end else if (clear) begin
         balls_r <= 3'd0;
         overs_r <= 4'd0;
      end else if (advance) begin
         if (wrap_s) begin
            balls_r <= 3'd0;
            overs_r <= overs_r + 4'd1;
         end else begin
            balls_r <= balls_r + 3'd1;
         end
      end
   end

   assign balls = balls_r;
   assign overs = overs_r;

endmodule

// File: rtl/innings_sequencer.sv
// Two-innings limited-overs match sequencer: scores each delivery, tracks
// the innings limits, sets the chase target and decides the result.
module innings_sequencer
   import cricket_pkg::*;
#(
   parameter int MAX_OVERS      = DEF_MAX_OVERS,
   parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
   parameter int MAX_WICKETS    = DEF_MAX_WICKETS
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic       delivery,
   input  logic [2:0] outcome,
   input  logic       next_inning,
   output logic [7:0] runs,
   output logic [3:0] wickets,
   output logic [2:0] balls,
   output logic [3:0] overs,
   output logic       batting_team,
   output logic [8:0] target,
   output logic       inning_over,
   output logic       game_over,
   output logic       winner,
   output logic       tie
);

   localparam logic [3:0] WICKET_LIMIT = 4'(MAX_WICKETS);

   innings_state_e state_r;
   logic [7:0]     runs_r;
   logic [3:0]     wickets_r;
   logic           batting_team_r;
   logic [8:0]     target_r;
   logic           inning_over_r;
   logic           game_over_r;
   logic           winner_r;
   logic           tie_r;

   logic           scoring_s;
   logic           restart_s;
   logic [7:0]     runs_next_s;
   logic [3:0]     wickets_next_s;
   logic           wicket_limit_s;
   logic           over_limit_s;
   logic           chase_met_s;
   logic           level_s;

   // A delivery only counts while an innings is in progress; next_inning only acts in the break.
   always_comb begin
      scoring_s = 1'b0;
      restart_s = 1'b0;
      if (delivery && ((state_r == ST_INN1) || (state_r == ST_INN2))) begin
         scoring_s = 1'b1;
      end else begin
         scoring_s = 1'b0;
      end
      if (next_inning && (state_r == ST_BREAK)) begin
         restart_s = 1'b1;
      end else begin
         restart_s = 1'b0;
      end
   end

   // Score after this ball, plus the limit and result conditions it produces.
   always_comb begin
      runs_next_s    = runs_r;
      wickets_next_s = wickets_r;
      wicket_limit_s = 1'b0;
      if (scoring_s) begin
         if (outcome == OUTCOME_WICKET) begin
            wickets_next_s = wickets_r + 4'd1;
         end else begin
            runs_next_s = sat_add_runs(runs_r, outcome);
         end
         if (wickets_next_s == WICKET_LIMIT) begin
            wicket_limit_s = 1'b1;
         end else begin
            wicket_limit_s = 1'b0;
         end
      end else begin
         runs_next_s    = runs_r;
         wickets_next_s = wickets_r;
         wicket_limit_s = 1'b0;
      end
      chase_met_s = ({1'b0, runs_next_s} >= target_r);
      level_s     = (({1'b0, runs_next_s} + 9'd1) == target_r);
   end

   ball_counter #(
      .BALLS_PER_OVER (BALLS_PER_OVER),
      .MAX_OVERS      (MAX_OVERS)
   ) u_ball_counter (
      .clk_fpga   (clk_fpga),
      .reset      (reset),
      .advance    (scoring_s),
      .clear      (restart_s),
      .balls      (balls),
      .overs      (overs),
      .over_limit (over_limit_s)
   );

   // Match phase register with the score and result outputs it owns.
   always_ff @(posedge clk_fpga or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_INN1;
         runs_r         <= 8'd0;
         wickets_r      <= 4'd0;
         batting_team_r <= 1'b0;
         target_r       <= 9'd0;
         inning_over_r  <= 1'b0;
         game_over_r    <= 1'b0;
         winner_r       <= 1'b0;
         tie_r          <= 1'b0;
      end else begin
         case (state_r)
            ST_INN1: begin
               if (scoring_s) begin
                  runs_r    <= runs_next_s;
                  wickets_r <= wickets_next_s;
                  if (wicket_limit_s || over_limit_s) begin
                     state_r       <= ST_BREAK;
                     inning_over_r <= 1'b1;
                     target_r      <= {1'b0, runs_next_s} + 9'd1;
                  end
               end
            end
            ST_BREAK: begin
               if (restart_s) begin
                  state_r        <= ST_INN2;
                  runs_r         <= 8'd0;
                  wickets_r      <= 4'd0;
                  batting_team_r <= 1'b1;
                  inning_over_r  <= 1'b0;
               end
            end
            ST_INN2: begin
               if (scoring_s) begin
                  runs_r    <= runs_next_s;
                  wickets_r <= wickets_next_s;
                  // Reaching the target wins outright, even on the ball that hits a limit.
                  if (chase_met_s) begin
                     state_r     <= ST_DONE;
                     game_over_r <= 1'b1;
                     winner_r    <= 1'b1;
                  end else if (wicket_limit_s || over_limit_s) begin
                     state_r     <= ST_DONE;
                     game_over_r <= 1'b1;
                     if (level_s) begin
                        tie_r <= 1'b1;
                     end else begin
                        winner_r <= 1'b0;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_DONE;
            end
            default: begin
               state_r <= ST_INN1;
            end
         endcase
      end
   end

   assign runs         = runs_r;
   assign wickets      = wickets_r;
   assign batting_team = batting_team_r;
   assign target       = target_r;
   assign inning_over  = inning_over_r;
   assign game_over    = game_over_r;
   assign winner       = winner_r;
   assign tie          = tie_r;

endmodule
